// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared constants and helpers for the clock divider block
package clock_div_pkg;

   localparam int unsigned CLK_FREQ_HZ = 100_000_000;

   function automatic int unsigned half_for_hz(input int unsigned f);
      return CLK_FREQ_HZ / (2 * f);
   endfunction

   // A HALF of 1 still needs one counter bit to keep the port widths legal.
   function automatic int cnt_width(input int unsigned half);
      return (half <= 1) ? 1 : $clog2(half);
   endfunction

   localparam int unsigned DEF_DCLK_HALF  = half_for_hz(25_000_000);
   localparam int unsigned DEF_SEG_HALF   = 131072;
   localparam int unsigned DEF_SCORE_HALF = half_for_hz(1);
   localparam int unsigned DEF_PLR_HALF   = half_for_hz(10);
   localparam int unsigned DEF_GAME_HALF  = half_for_hz(20);

endpackage

// File: rtl/clock_div_if.sv
// rtl/clock_div_if.sv - divided clock outputs bundle; strobes present under CLOCK_DIV_STROBE_EN
interface clock_div_if;

   logic dclk;
   logic segclk;
   logic scoreclk;
   logic plrclk;
   logic gameclk;
`ifdef CLOCK_DIV_STROBE_EN
   logic seg_stb;
   logic score_stb;
   logic plr_stb;
   logic game_stb;
`endif

`ifdef CLOCK_DIV_STROBE_EN
   modport master (output dclk, segclk, scoreclk, plrclk, gameclk,
                   seg_stb, score_stb, plr_stb, game_stb);
   modport slave  (input  dclk, segclk, scoreclk, plrclk, gameclk,
                   seg_stb, score_stb, plr_stb, game_stb);
`else
   modport master (output dclk, segclk, scoreclk, plrclk, gameclk);
   modport slave  (input  dclk, segclk, scoreclk, plrclk, gameclk);
`endif

endinterface

// File: rtl/clock_div_stage.sv
// rtl/clock_div_stage.sv - one toggle divider, out = f_clk/(2*HALF); stb under CLOCK_DIV_STROBE_EN
module clock_div_stage
   import clock_div_pkg::*;
#(
   parameter int unsigned HALF = 2
) (
   input  logic clk,
   input  logic clr,
`ifdef CLOCK_DIV_STROBE_EN
   output logic stb,
`endif
   output logic out
);

   localparam int W = cnt_width(HALF);
   localparam logic [W-1:0] LAST = W'(HALF - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] cnt;
   logic         tick;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (tick) begin
         cnt <= '0;
         out <= ~out;
      end else begin
         cnt <= cnt + ONE;
      end
   end

`ifdef CLOCK_DIV_STROBE_EN
   // Fires on the same edge that takes out from 0 to 1.
   always_ff @(posedge clk) begin
      if (clr) begin
         stb <= 1'b0;
      end else begin
         stb <= tick & ~out;
      end
   end
`endif

endmodule

// File: rtl/clock_div.sv
// rtl/clock_div.sv - game clock generator top; optional strobes under CLOCK_DIV_STROBE_EN
module clock_div
   import clock_div_pkg::*;
#(
   parameter int unsigned DCLK_HALF  = DEF_DCLK_HALF,
   parameter int unsigned SEG_HALF   = DEF_SEG_HALF,
   parameter int unsigned SCORE_HALF = DEF_SCORE_HALF,
   parameter int unsigned PLR_HALF   = DEF_PLR_HALF,
   parameter int unsigned GAME_HALF  = DEF_GAME_HALF
) (
   input  logic         clk,
   input  logic         clr,
   clock_div_if.master  clks
);

`ifdef CLOCK_DIV_STROBE_EN
   logic dclk_stb_unused;

   clock_div_stage #(.HALF(DCLK_HALF)) u_dclk (
      .clk(clk), .clr(clr), .stb(dclk_stb_unused), .out(clks.dclk));
   clock_div_stage #(.HALF(SEG_HALF)) u_seg (
      .clk(clk), .clr(clr), .stb(clks.seg_stb), .out(clks.segclk));
   clock_div_stage #(.HALF(SCORE_HALF)) u_score (
      .clk(clk), .clr(clr), .stb(clks.score_stb), .out(clks.scoreclk));
   clock_div_stage #(.HALF(PLR_HALF)) u_plr (
      .clk(clk), .clr(clr), .stb(clks.plr_stb), .out(clks.plrclk));
   clock_div_stage #(.HALF(GAME_HALF)) u_game (
      .clk(clk), .clr(clr), .stb(clks.game_stb), .out(clks.gameclk));
`else
   clock_div_stage #(.HALF(DCLK_HALF)) u_dclk (
      .clk(clk), .clr(clr), .out(clks.dclk));
   clock_div_stage #(.HALF(SEG_HALF)) u_seg (
      .clk(clk), .clr(clr), .out(clks.segclk));
   clock_div_stage #(.HALF(SCORE_HALF)) u_score (
      .clk(clk), .clr(clr), .out(clks.scoreclk));
   clock_div_stage #(.HALF(PLR_HALF)) u_plr (
      .clk(clk), .clr(clr), .out(clks.plrclk));
   clock_div_stage #(.HALF(GAME_HALF)) u_game (
      .clk(clk), .clr(clr), .out(clks.gameclk));
`endif

endmodule

// File: tb/tb_clock_div.sv
// tb/tb_clock_div.sv - scoreboard bench for clock_div and a HALF=1 stage; honours CLOCK_DIV_STROBE_EN
module tb_clock_div;

   localparam int unsigned H_DCLK  = 2;
   localparam int unsigned H_SEG   = 4;
   localparam int unsigned H_SCORE = 10;
   localparam int unsigned H_PLR   = 5;
   localparam int unsigned H_GAME  = 3;

   typedef struct {
      int unsigned edge_n;
      logic dclk, segclk, scoreclk, plrclk, gameclk, h1;
      logic seg_stb, score_stb, plr_stb, game_stb, h1_stb;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic h1_out;
`ifdef CLOCK_DIV_STROBE_EN
   logic h1_stb;
`endif

   clock_div_if clks ();

   clock_div #(
      .DCLK_HALF(H_DCLK), .SEG_HALF(H_SEG), .SCORE_HALF(H_SCORE),
      .PLR_HALF(H_PLR), .GAME_HALF(H_GAME)
   ) dut (
      .clk(clk), .clr(clr), .clks(clks)
   );

`ifdef CLOCK_DIV_STROBE_EN
   clock_div_stage #(.HALF(1)) u_h1 (.clk(clk), .clr(clr), .stb(h1_stb), .out(h1_out));
`else
   clock_div_stage #(.HALF(1)) u_h1 (.clk(clk), .clr(clr), .out(h1_out));
`endif

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_run = 0;
   int unsigned edge_cnt = 0;
   exp_t sb_q[$];

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d want %0d", tag, edge_cnt, obs, exp);
      end
   endtask

   // Output after n unreset edges: phase flips every HALF edges, starting low.
   function automatic logic f_out(input int unsigned n, input int unsigned half);
      return ((n / half) % 2) == 1;
   endfunction

   function automatic logic f_stb(input int unsigned n, input int unsigned half);
      return (n != 0) && (n % half == 0) && f_out(n, half);
   endfunction

   task automatic step(input logic c);
      exp_t e;
      clr = c;
      n_run = c ? 0 : n_run + 1;
      e.edge_n    = n_run;
      e.dclk      = f_out(n_run, H_DCLK);
      e.segclk    = f_out(n_run, H_SEG);
      e.scoreclk  = f_out(n_run, H_SCORE);
      e.plrclk    = f_out(n_run, H_PLR);
      e.gameclk   = f_out(n_run, H_GAME);
      e.h1        = f_out(n_run, 1);
      e.seg_stb   = f_stb(n_run, H_SEG);
      e.score_stb = f_stb(n_run, H_SCORE);
      e.plr_stb   = f_stb(n_run, H_PLR);
      e.game_stb  = f_stb(n_run, H_GAME);
      e.h1_stb    = f_stb(n_run, 1);
      sb_q.push_back(e);
      @(posedge clk);
      edge_cnt++;
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check("dclk",     clks.dclk,     e.dclk);
         check("segclk",   clks.segclk,   e.segclk);
         check("scoreclk", clks.scoreclk, e.scoreclk);
         check("plrclk",   clks.plrclk,   e.plrclk);
         check("gameclk",  clks.gameclk,  e.gameclk);
         check("half1",    h1_out,        e.h1);
`ifdef CLOCK_DIV_STROBE_EN
         check("seg_stb",   clks.seg_stb,   e.seg_stb);
         check("score_stb", clks.score_stb, e.score_stb);
         check("plr_stb",   clks.plr_stb,   e.plr_stb);
         check("game_stb",  clks.game_stb,  e.game_stb);
         check("half1_stb", h1_stb,         e.h1_stb);
`endif
      end
   endtask

   initial begin
      step(1'b1);
      check("cnt_dclk_rst",  dut.u_dclk.cnt,  0);
      check("cnt_seg_rst",   dut.u_seg.cnt,   0);
      check("cnt_score_rst", dut.u_score.cnt, 0);
      check("cnt_plr_rst",   dut.u_plr.cnt,   0);
      check("cnt_game_rst",  dut.u_game.cnt,  0);
      step(1'b1);
      step(1'b1);

      for (int i = 0; i < 60; i++) step(1'b0);

      // Land a reset on scoreclk high with its counter at 6.
      step(1'b1);
      for (int i = 0; i < 16; i++) step(1'b0);
      check("score_cnt_pre", dut.u_score.cnt, 6);
      check("score_hi_pre", clks.scoreclk, 1);
      step(1'b1);
      check("score_cnt_clr", dut.u_score.cnt, 0);
      for (int i = 0; i < 40; i++) step(1'b0);

      for (int i = 0; i < 300; i++) step($urandom_range(0, 24) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
